serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with valid/ready handshakes on both sides.
// One 1-bit full-adder cell is reused over WIDTH cycles, LSB first, with a
// carry flip-flop between cycles. FSM: IDLE -> RUN (WIDTH cycles) -> DONE.
// Optional feature macro: SERIAL_ADDER_CTRL_SUB_EN adds input 'sub'. The
// operand pair is latched with it. sub=1 computes a - b, and c=1 then means
// no borrow.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. in_ready and out_valid are decoded from the state register
// only. A producer may change a/b/in_valid freely while in_ready=0. r/c hold
// steady while out_valid=1 until out_ready=1 is seen at an edge.
// state_dbg exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;
  logic             carry_init;

  // Operand bit selection. When subtracting, b is inverted and carry starts at 1.
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  logic sub_q;

  // Latch the operation select together with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_q <= sub;
    end
  end

  assign b_bit      = b_q[cnt] ^ sub_q;
  assign carry_init = sub;
`else
  assign b_bit      = b_q[cnt];
  assign carry_init = 1'b0;
`endif

  assign a_bit    = a_q[cnt];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The single shared full-adder cell.
  assign sum_bit    = a_bit ^ b_bit ^ carry;
  assign carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then process one bit per cycle.
  // r/c are written only in RUN, so they stay frozen throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            carry <= carry_init;
          end
        end
        RUN: begin
          r_q[cnt] <= sum_bit;
          carry    <= carry_next;
          cnt      <= cnt + CW'(1);
          if (last_bit) begin
            c_q <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign r         = r_q;
  assign c         = c_q;
  assign state_dbg = state;

endmodule
